// File: rtl/uio_bus_sched_if.sv
// Bus bundle between the uio scheduler and its requesters / pad ring.
interface uio_bus_sched_if;
  logic       ena;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       busy;
  logic       last_grant;

  // Scheduler side.
  modport slave (
    input  ena, wr_valid, wr_data, rd_req, uio_in,
    output wr_ready, rd_valid, rd_data, uio_out, uio_oe, busy, last_grant
  );

  // Requester / environment side.
  modport master (
    output ena, wr_valid, wr_data, rd_req, uio_in,
    input  wr_ready, rd_valid, rd_data, uio_out, uio_oe, busy, last_grant
  );
endinterface

// File: rtl/uio_bus_sched.sv
// Round-robin scheduler sharing one bidirectional uio bus between a write
// requester (drives a word for HOLD_CYC cycles) and a read requester (samples
// the bus once). All bus-facing outputs are registered; only wr_ready is
// combinational.
module uio_bus_sched #(
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned TURN_CYC = 1,
  parameter logic [7:0]  OE_MASK  = 8'hFF
) (
  input logic            clk,
  input logic            rst,
  uio_bus_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StTurn, StSample} state_e;

  localparam logic [3:0] HoldLd = 4'(HOLD_CYC - 1);
  localparam logic [3:0] TurnLd = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);

  state_e     r_state, w_state_d;
  logic [3:0] r_cnt, w_cnt_d;
  logic       r_last_grant;
  logic [7:0] r_uio_out;
  logic [7:0] r_uio_oe;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;
  logic       r_busy;

  logic w_wr_win;
  logic w_rd_win;
  logic w_wr_acc;
  logic w_rd_acc;

  // Arbitration: a lone requester wins; on a tie, the one not granted last wins.
  always_comb begin
    w_wr_win = bus.wr_valid & (~bus.rd_req | r_last_grant);
    w_rd_win = bus.rd_req & (~bus.wr_valid | ~r_last_grant);
    w_wr_acc = (r_state == StIdle) & bus.ena & w_wr_win;
    w_rd_acc = (r_state == StIdle) & bus.ena & w_rd_win;
  end

  // Next-state and hold/turn counter.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_wr_acc) begin
          w_state_d = StDrive;
          w_cnt_d   = HoldLd;
        end else if (w_rd_acc) begin
          w_state_d = StSample;
        end
      end
      StDrive: begin
        if (r_cnt == 4'd0) begin
          if (TURN_CYC == 0) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StTurn;
            w_cnt_d   = TurnLd;
          end
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StTurn: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StSample: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // State, counter and grant history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_wr_acc) begin
        r_last_grant <= 1'b0;
      end else if (w_rd_acc) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  // Registered bus outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uio_out  <= 8'h00;
      r_uio_oe   <= 8'h00;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      // The word is captured once at acceptance so later wr_data changes are ignored.
      if (w_wr_acc) begin
        r_uio_out <= bus.wr_data & OE_MASK;
      end else if (w_state_d != StDrive) begin
        r_uio_out <= 8'h00;
      end
      r_uio_oe   <= (w_state_d == StDrive) ? OE_MASK : 8'h00;
      r_busy     <= (w_state_d != StIdle);
      r_rd_valid <= (r_state == StSample);
      if (r_state == StSample) begin
        r_rd_data <= bus.uio_in;
      end
    end
  end

  assign bus.wr_ready   = w_wr_acc;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_data;
  assign bus.uio_out    = r_uio_out;
  assign bus.uio_oe     = r_uio_oe;
  assign bus.busy       = r_busy;
  assign bus.last_grant = r_last_grant;

endmodule
